// File: rtl/i2c_domain_result_buf_if.sv
// Read-side bundle of the per-domain result buffer.
//   d1_data/d1_valid/d1_ready : D1 head and handshake
//   d2_data/d2_valid/d2_ready : D2 head and handshake
// master = buffer side (drives data/valid), slave = consumer side (drives ready).
interface i2c_domain_result_buf_if;
  logic [7:0] d1_data;
  logic       d1_valid;
  logic       d1_ready;
  logic [7:0] d2_data;
  logic       d2_valid;
  logic       d2_ready;

  modport master (
    output d1_data, d1_valid, d2_data, d2_valid,
    input  d1_ready, d2_ready
  );

  modport slave (
    input  d1_data, d1_valid, d2_data, d2_valid,
    output d1_ready, d2_ready
  );
endinterface

// File: rtl/i2c_domain_result_buf.sv
// Per-domain result buffer. Every rd_data/valid result is tagged with the
// domain of the previous cycle (dom_q) and queued in that domain's FIFO.
// Each FIFO drains through its own read port, only while its slot is active.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   domain_i2c        : current slot domain (0 = D1, 1 = D2)
//   rd_data, valid    : result byte and its one-cycle strobe
//   done              : end-of-sweep strobe, counted in sweep_cnt
//   rd_if (master)    : D1/D2 head data, valid and ready
//   d1_count/d2_count : FIFO occupancy
//   d1_ovf/d2_ovf     : sticky overflow flags, cleared by clr_ovf
//   sweep_cnt         : completed sweeps, wrapping
module i2c_domain_result_buf #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   domain_i2c,
  input  logic [7:0]             rd_data,
  input  logic                   valid,
  input  logic                   done,
  i2c_domain_result_buf_if.master rd_if,
  output logic [PTR_W:0]         d1_count,
  output logic [PTR_W:0]         d2_count,
  output logic                   d1_ovf,
  output logic                   d2_ovf,
  input  logic                   clr_ovf,
  output logic [7:0]             sweep_cnt
);

  localparam logic [PTR_W:0]   FULL_CNT = DEPTH[PTR_W:0];
  localparam logic [PTR_W:0]   CNT_ONE  = 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = 1;

  logic                   dom_q;
  logic [7:0]             mem_q [2][DEPTH];
  logic [PTR_W-1:0]       wp_q [2];
  logic [PTR_W-1:0]       wp_d [2];
  logic [PTR_W-1:0]       rp_q [2];
  logic [PTR_W-1:0]       rp_d [2];
  logic [PTR_W:0]         cnt_q [2];
  logic [PTR_W:0]         cnt_d [2];
  logic [1:0]             ovf_q, ovf_d;
  logic [7:0]             sweep_q, sweep_d;

  logic [1:0]             slot, ready, nonempty, pop, push, full, acc, ovf_ev;
  logic [7:0]             head [2];

  always_comb begin
    slot  = {domain_i2c, ~domain_i2c};
    ready = {rd_if.d2_ready, rd_if.d1_ready};
    push  = {valid & dom_q, valid & ~dom_q};
    sweep_d = done ? sweep_q + 8'd1 : sweep_q;
    for (int unsigned k = 0; k < 2; k++) begin
      nonempty[k] = (cnt_q[k] != '0);
      full[k]     = (cnt_q[k] == FULL_CNT);
      pop[k]      = nonempty[k] & slot[k] & ready[k];
      // A full FIFO still accepts a push when it pops in the same cycle.
      acc[k]      = push[k] & (~full[k] | pop[k]);
      ovf_ev[k]   = push[k] & full[k] & ~pop[k];
      wp_d[k]     = acc[k] ? wp_q[k] + PTR_ONE : wp_q[k];
      rp_d[k]     = pop[k] ? rp_q[k] + PTR_ONE : rp_q[k];
      cnt_d[k]    = cnt_q[k];
      case ({acc[k], pop[k]})
        2'b10:   cnt_d[k] = cnt_q[k] + CNT_ONE;
        2'b01:   cnt_d[k] = cnt_q[k] - CNT_ONE;
        default: cnt_d[k] = cnt_q[k];
      endcase
      // Set wins over a same-cycle clear.
      ovf_d[k]    = ovf_ev[k] | (ovf_q[k] & ~clr_ovf);
      head[k]     = nonempty[k] ? mem_q[k][rp_q[k]] : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dom_q   <= 1'b0;
      ovf_q   <= '0;
      sweep_q <= '0;
      for (int unsigned k = 0; k < 2; k++) begin
        wp_q[k]  <= '0;
        rp_q[k]  <= '0;
        cnt_q[k] <= '0;
      end
    end else begin
      dom_q   <= domain_i2c;
      ovf_q   <= ovf_d;
      sweep_q <= sweep_d;
      for (int unsigned k = 0; k < 2; k++) begin
        wp_q[k]  <= wp_d[k];
        rp_q[k]  <= rp_d[k];
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  // Storage is not reset; the head mux masks it while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (|acc) mem_q[dom_q][wp_q[dom_q]] <= rd_data;
  end

  assign rd_if.d1_data  = head[0];
  assign rd_if.d2_data  = head[1];
  assign rd_if.d1_valid = nonempty[0] & slot[0];
  assign rd_if.d2_valid = nonempty[1] & slot[1];
  assign d1_count       = cnt_q[0];
  assign d2_count       = cnt_q[1];
  assign d1_ovf         = ovf_q[0];
  assign d2_ovf         = ovf_q[1];
  assign sweep_cnt      = sweep_q;

endmodule

// File: tb/tb_i2c_domain_result_buf.sv
module tb_i2c_domain_result_buf;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             domain_i2c, valid, done, clr_ovf;
  logic [7:0]       rd_data;
  logic [PTR_W:0]   d1_count, d2_count;
  logic             d1_ovf, d2_ovf;
  logic [7:0]       sweep_cnt;

  i2c_domain_result_buf_if rd_if ();

  i2c_domain_result_buf #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .domain_i2c (domain_i2c),
    .rd_data    (rd_data),
    .valid      (valid),
    .done       (done),
    .rd_if      (rd_if),
    .d1_count   (d1_count),
    .d2_count   (d2_count),
    .d1_ovf     (d1_ovf),
    .d2_ovf     (d2_ovf),
    .clr_ovf    (clr_ovf),
    .sweep_cnt  (sweep_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: two plain queues plus flags.
  byte unsigned q1[$];
  byte unsigned q2[$];
  bit           m_ovf1, m_ovf2, m_dom;
  byte unsigned m_sweep;

  function automatic logic [PTR_W:0] e_cnt(input bit k);
    return k ? (PTR_W+1)'(q2.size()) : (PTR_W+1)'(q1.size());
  endfunction

  function automatic logic [7:0] e_head(input bit k);
    if (k) return (q2.size() != 0) ? q2[0] : 8'h00;
    return (q1.size() != 0) ? q1[0] : 8'h00;
  endfunction

  function automatic logic e_valid(input bit k);
    return (e_cnt(k) != 0) && (domain_i2c == k);
  endfunction

  task automatic model_reset();
    q1.delete(); q2.delete();
    m_ovf1 = 0; m_ovf2 = 0; m_dom = 0; m_sweep = 0;
  endtask

  // Drive one cycle of inputs, advance the model, then step past the edge.
  task automatic step(input bit dom, input bit v, input logic [7:0] d,
                      input bit dn, input bit r1, input bit r2, input bit clr);
    bit ev1, ev2;
    domain_i2c = dom; valid = v; rd_data = d; done = dn;
    rd_if.d1_ready = r1; rd_if.d2_ready = r2; clr_ovf = clr;
    ev1 = 0; ev2 = 0;
    if (q1.size() != 0 && !dom && r1) void'(q1.pop_front());
    if (q2.size() != 0 && dom && r2)  void'(q2.pop_front());
    if (v) begin
      if (!m_dom) begin
        if (q1.size() < DEPTH) q1.push_back(d); else ev1 = 1;
      end else begin
        if (q2.size() < DEPTH) q2.push_back(d); else ev2 = 1;
      end
    end
    m_ovf1 = ev1 | (m_ovf1 & !clr);
    m_ovf2 = ev2 | (m_ovf2 & !clr);
    if (dn) m_sweep++;
    m_dom = dom;
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    valid = 0; done = 0; clr_ovf = 0; domain_i2c = 0; rd_data = 8'h00;
    rd_if.d1_ready = 0; rd_if.d2_ready = 0;
    model_reset();
    #2;
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    apply_reset();
    #10;
    checks++; if (d1_count !== 0 || d2_count !== 0) begin errors++;
      $display("FAIL reset_count got %0d/%0d want 0/0", d1_count, d2_count); end
    checks++; if (rd_if.d1_data !== 8'h00 || rd_if.d2_data !== 8'h00) begin errors++;
      $display("FAIL reset_data got %h/%h want 00/00", rd_if.d1_data, rd_if.d2_data); end
    checks++; if (rd_if.d1_valid !== 1'b0 || rd_if.d2_valid !== 1'b0) begin errors++;
      $display("FAIL reset_valid got %b/%b want 0/0", rd_if.d1_valid, rd_if.d2_valid); end
    checks++; if (d1_ovf !== 1'b0 || d2_ovf !== 1'b0 || sweep_cnt !== 8'h00) begin errors++;
      $display("FAIL reset_flags got ovf %b/%b sweep %h want 0/0 00", d1_ovf, d2_ovf, sweep_cnt); end
    release_reset();
  endtask

  task automatic test_basic_routing();
    step(0, 1, 8'h12, 0, 0, 0, 0);
    step(1, 0, 8'hEE, 0, 0, 0, 0);
    step(1, 1, 8'h90, 1, 0, 0, 0);
    checks++; if (d1_count !== e_cnt(0) || d2_count !== e_cnt(1) || e_cnt(0) != 1) begin errors++;
      $display("FAIL route_count got %0d/%0d want %0d/%0d", d1_count, d2_count, e_cnt(0), e_cnt(1)); end
    checks++; if (rd_if.d1_data !== e_head(0) || rd_if.d2_data !== e_head(1)) begin errors++;
      $display("FAIL route_data got %h/%h want %h/%h", rd_if.d1_data, rd_if.d2_data, e_head(0), e_head(1)); end
    checks++; if (sweep_cnt !== m_sweep) begin errors++;
      $display("FAIL route_sweep got %h want %h", sweep_cnt, m_sweep); end
    checks++; if (rd_if.d2_valid !== e_valid(1) || rd_if.d1_valid !== e_valid(0)) begin errors++;
      $display("FAIL route_valid got %b/%b want %b/%b", rd_if.d1_valid, rd_if.d2_valid, e_valid(0), e_valid(1)); end
  endtask

  task automatic test_slot_gating();
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 8'h00, 0, 1, 0, 0);
      checks++; if (rd_if.d1_valid !== 1'b0 || d1_count !== e_cnt(0)) begin errors++;
        $display("FAIL gate_hold cyc %0d got valid %b cnt %0d want 0 %0d", i, rd_if.d1_valid, d1_count, e_cnt(0)); end
    end
    domain_i2c = 0; #1;
    checks++; if (rd_if.d1_valid !== 1'b1 || rd_if.d1_data !== e_head(0)) begin errors++;
      $display("FAIL gate_open got valid %b data %h want 1 %h", rd_if.d1_valid, rd_if.d1_data, e_head(0)); end
    step(0, 0, 8'h00, 0, 1, 0, 0);
    checks++; if (d1_count !== e_cnt(0) || rd_if.d1_valid !== e_valid(0)) begin errors++;
      $display("FAIL gate_pop got cnt %0d valid %b want %0d %b", d1_count, rd_if.d1_valid, e_cnt(0), e_valid(0)); end
  endtask

  task automatic test_overflow();
    apply_reset(); release_reset();
    for (int i = 1; i <= 5; i++) step(0, 1, 8'(i), 0, 0, 0, 0);
    checks++; if (d1_count !== e_cnt(0) || d1_ovf !== m_ovf1 || !m_ovf1) begin errors++;
      $display("FAIL ovf_full got cnt %0d ovf %b want %0d %b", d1_count, d1_ovf, e_cnt(0), m_ovf1); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rd_if.d1_data !== e_head(0) || rd_if.d1_valid !== 1'b1) begin errors++;
        $display("FAIL ovf_pop %0d got %h want %h", i, rd_if.d1_data, e_head(0)); end
      step(0, 0, 8'h00, 0, 1, 0, 0);
    end
    step(0, 0, 8'h00, 0, 0, 0, 1);
    checks++; if (d1_ovf !== m_ovf1 || d1_count !== 0) begin errors++;
      $display("FAIL ovf_clear got ovf %b cnt %0d want %b 0", d1_ovf, d1_count, m_ovf1); end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 4; i++) step(0, 1, 8'hA0 + 8'(i), 0, 0, 0, 0);
    step(0, 1, 8'hA4, 0, 1, 0, 0);
    checks++; if (d1_ovf !== 1'b0 || d1_count !== e_cnt(0) || e_cnt(0) != 4) begin errors++;
      $display("FAIL fullpp got ovf %b cnt %0d want 0 %0d", d1_ovf, d1_count, e_cnt(0)); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rd_if.d1_data !== e_head(0)) begin errors++;
        $display("FAIL fullpp_pop %0d got %h want %h", i, rd_if.d1_data, e_head(0)); end
      step(0, 0, 8'h00, 0, 1, 0, 0);
    end
  endtask

  task automatic test_tag_boundary();
    step(0, 0, 8'h00, 0, 0, 0, 0);
    step(1, 1, 8'h55, 0, 0, 0, 0);
    checks++; if (d1_count !== e_cnt(0) || d2_count !== 0 || rd_if.d1_data !== e_head(0)) begin errors++;
      $display("FAIL tag got d1 %0d/%h d2 %0d want %0d/%h 0", d1_count, rd_if.d1_data, d2_count, e_cnt(0), e_head(0)); end
  endtask

  task automatic test_clr_vs_ovf();
    for (int i = 0; i < DEPTH + 1; i++) step(1, 1, 8'hC0 + 8'(i), 0, 0, 0, 0);
    step(1, 1, 8'hCF, 0, 0, 0, 1);
    checks++; if (d2_ovf !== m_ovf2 || !m_ovf2 || d2_count !== e_cnt(1)) begin errors++;
      $display("FAIL clr_vs_ovf got ovf %b cnt %0d want %b %0d", d2_ovf, d2_count, m_ovf2, e_cnt(1)); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom), 1'($urandom), 8'($urandom), ($urandom_range(7) == 0),
           1'($urandom), 1'($urandom), ($urandom_range(15) == 0));
      checks++;
      if (d1_count !== e_cnt(0) || d2_count !== e_cnt(1) ||
          rd_if.d1_data !== e_head(0) || rd_if.d2_data !== e_head(1) ||
          rd_if.d1_valid !== e_valid(0) || rd_if.d2_valid !== e_valid(1) ||
          d1_ovf !== m_ovf1 || d2_ovf !== m_ovf2 || sweep_cnt !== m_sweep) begin
        errors++;
        $display("FAIL rand cyc %0d got c%0d/%0d d%h/%h v%b%b o%b%b s%h want c%0d/%0d d%h/%h v%b%b o%b%b s%h",
                 i, d1_count, d2_count, rd_if.d1_data, rd_if.d2_data, rd_if.d1_valid, rd_if.d2_valid,
                 d1_ovf, d2_ovf, sweep_cnt, e_cnt(0), e_cnt(1), e_head(0), e_head(1),
                 e_valid(0), e_valid(1), m_ovf1, m_ovf2, m_sweep);
      end
    end
  endtask

  task automatic test_reset_mid();
    step(0, 1, 8'h31, 1, 0, 0, 0);
    step(1, 1, 8'h32, 0, 0, 0, 0);
    step(1, 1, 8'h33, 0, 0, 0, 0);
    checks++; if (d1_count === 0 || d2_count === 0) begin errors++;
      $display("FAIL rstmid_pre got %0d/%0d want both nonzero", d1_count, d2_count); end
    #2 apply_reset();
    checks++; if (d1_count !== 0 || d2_count !== 0 || rd_if.d1_data !== 0 || rd_if.d2_data !== 0 ||
                  d1_ovf !== 0 || d2_ovf !== 0 || sweep_cnt !== 0) begin errors++;
      $display("FAIL rstmid got c%0d/%0d d%h/%h o%b%b s%h want all 0", d1_count, d2_count,
               rd_if.d1_data, rd_if.d2_data, d1_ovf, d2_ovf, sweep_cnt); end
    release_reset();
  endtask

  task automatic test_wrap();
    apply_reset(); release_reset();
    for (int i = 0; i < 255; i++) step(1, 0, 8'h00, 1, 0, 0, 0);
    checks++; if (sweep_cnt !== 8'hFF) begin errors++;
      $display("FAIL wrap_ff got %h want ff", sweep_cnt); end
    step(1, 0, 8'h00, 1, 0, 0, 0);
    checks++; if (sweep_cnt !== 8'h00 || sweep_cnt !== m_sweep) begin errors++;
      $display("FAIL wrap_00 got %h want 00", sweep_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic_routing();
    test_slot_gating();
    test_overflow();
    test_full_push_pop();
    test_tag_boundary();
    test_clr_vs_ovf();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
